// File: rtl/i2c_cmd_sequencer_pkg.sv
// Shared widths, FSM states, response codes and the command FIFO entry layout.
package i2c_cmd_sequencer_pkg;

    localparam int ADDR_W  = 7;
    localparam int NTX_W   = 3;
    localparam int NRX_W   = 5;
    localparam int TXD_W   = 56;
    localparam int RXD_W   = 248;
    localparam int ENTRY_W = ADDR_W + 1 + NTX_W + NRX_W + TXD_W;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_NO_START = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESPOND
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] sl_addr;
        logic              rep_start;
        logic [NTX_W-1:0]  num_tx;
        logic [NRX_W-1:0]  num_rx;
        logic [TXD_W-1:0]  data;
    } cmd_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous show-ahead FIFO for queued I2C commands.
// Latency: a pushed entry is visible on dout the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty.
module i2c_cmd_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C commands and issues them to i2c_master one at a time, returning one response each.
// Latency: push at edge N into an empty idle block gives M_START in cycle N+2.
// Backpressure: CMD_READY drops when the FIFO is full; a held response blocks the next launch.
module i2c_cmd_sequencer
    import i2c_cmd_sequencer_pkg::*;
#(
    parameter int CMD_FIFO_DEPTH   = 4,
    parameter int BUSY_WAIT_CYCLES = 8,
    parameter int TIMEOUT_CYCLES   = 2000000
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              CMD_VALID,
    output logic                              CMD_READY,
    input  logic [ADDR_W-1:0]                 CMD_SL_ADDR,
    input  logic                              CMD_REP_START,
    input  logic [NTX_W-1:0]                  CMD_NUM_TX,
    input  logic [NRX_W-1:0]                  CMD_NUM_RX,
    input  logic [TXD_W-1:0]                  CMD_DATA,
    output logic                              RSP_VALID,
    input  logic                              RSP_READY,
    output logic [ADDR_W-1:0]                 RSP_SL_ADDR,
    output logic [1:0]                        RSP_ERR,
    output logic [RXD_W-1:0]                  RSP_DATA,
    output logic [$clog2(CMD_FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                              M_START,
    output logic                              M_REP_START,
    output logic [ADDR_W-1:0]                 M_SL_ADDR,
    output logic [NTX_W-1:0]                  M_NUM_BYTES_TO_TRANSM,
    output logic [NRX_W-1:0]                  M_NUM_BYTES_TO_REC,
    output logic [TXD_W-1:0]                  M_DATA_TO_TRANSM,
    input  logic                              M_BUSY,
    input  logic [RXD_W-1:0]                  M_DATA_REC
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    cmd_t             cmd_in;
    cmd_t             cmd_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             busy_expired;
    logic             done_expired;

    assign cmd_in    = {CMD_SL_ADDR, CMD_REP_START, CMD_NUM_TX, CMD_NUM_RX, CMD_DATA};
    assign CMD_READY = !fifo_full;
    assign fifo_push = CMD_VALID && !fifo_full;
    // A still-busy master (e.g. after a timeout) holds the next launch in IDLE.
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && !RSP_VALID && !M_BUSY;

    i2c_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .din   (cmd_in),
        .pop   (fifo_pop),
        .dout  (cmd_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (FIFO_LEVEL)
    );

    assign busy_expired = (cnt == CNT_W'(BUSY_WAIT_CYCLES));
    assign done_expired = (cnt == CNT_W'(TIMEOUT_CYCLES));
    assign M_START      = (state == ST_LAUNCH);
    assign RSP_VALID    = (state == ST_RESPOND);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (fifo_pop) state_nxt = ST_LAUNCH;
            ST_LAUNCH:    state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (M_BUSY)            state_nxt = ST_WAIT_DONE;
                else if (busy_expired) state_nxt = ST_RESPOND;
            end
            ST_WAIT_DONE: if (!M_BUSY || done_expired) state_nxt = ST_RESPOND;
            ST_RESPOND:   if (RSP_READY) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Saturating wait counter shared by the busy-rise and transaction-length checks.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (state == ST_LAUNCH || (state == ST_WAIT_BUSY && M_BUSY)) begin
            cnt <= '0;
        end else if ((state == ST_WAIT_BUSY || state == ST_WAIT_DONE) && !(&cnt)) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            M_REP_START           <= 1'b0;
            M_SL_ADDR             <= '0;
            M_NUM_BYTES_TO_TRANSM <= '0;
            M_NUM_BYTES_TO_REC    <= '0;
            M_DATA_TO_TRANSM      <= '0;
            RSP_SL_ADDR           <= '0;
            RSP_ERR               <= ERR_OK;
            RSP_DATA              <= '0;
        end else begin
            if (fifo_pop) begin
                M_REP_START           <= cmd_head.rep_start;
                M_SL_ADDR             <= cmd_head.sl_addr;
                M_NUM_BYTES_TO_TRANSM <= cmd_head.num_tx;
                M_NUM_BYTES_TO_REC    <= cmd_head.num_rx;
                M_DATA_TO_TRANSM      <= cmd_head.data;
            end
            if (state == ST_WAIT_BUSY && !M_BUSY && busy_expired) begin
                RSP_SL_ADDR <= M_SL_ADDR;
                RSP_ERR     <= ERR_NO_START;
                RSP_DATA    <= '0;
            end
            if (state == ST_WAIT_DONE) begin
                if (!M_BUSY) begin
                    RSP_SL_ADDR <= M_SL_ADDR;
                    RSP_ERR     <= ERR_OK;
                    RSP_DATA    <= M_DATA_REC;
                end else if (done_expired) begin
                    RSP_SL_ADDR <= M_SL_ADDR;
                    RSP_ERR     <= ERR_TIMEOUT;
                    RSP_DATA    <= '0;
                end
            end
        end
    end

endmodule
